// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core.
//   - pc_src encodings, shared by the control unit and the fetch stage.
//   - fetch_state_t: states of the instruction fetch FSM.
package cpu_pkg;

    localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_REG    = 2'b10;
    localparam logic [1:0] PC_SRC_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StHold = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Next program counter selection (combinational).
// Ports:
//   pc_plus1       in  32  link value / sequential successor of the current PC
//   pc_src         in  2   branch / jump / register / sequential select
//   branch_cond    in  1   branch taken (only used for PC_SRC_BRANCH)
//   branch_offset  in  16  signed word offset
//   jump_target    in  26  J/JAL target field
//   rs_value       in  32  register target for JR/JALR
//   next_pc        out 32  selected next PC (modulo 2^32)
import cpu_pkg::*;

module next_pc (
    input  logic [31:0] pc_plus1,
    input  logic [1:0]  pc_src,
    input  logic        branch_cond,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] rs_value,
    output logic [31:0] next_pc
);

    logic [31:0] offset_ext;

    assign offset_ext = {{16{branch_offset[15]}}, branch_offset};

    always_comb begin
        next_pc = pc_plus1;
        case (pc_src)
            PC_SRC_BRANCH: next_pc = branch_cond ? (pc_plus1 + offset_ext) : pc_plus1;
            PC_SRC_JUMP:   next_pc = {pc_plus1[31:26], jump_target};
            PC_SRC_REG:    next_pc = rs_value;
            default:       next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack memory handshake and hands it to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pc_src, branch_cond,
//   branch_offset,
//   jump_target, rs_value  next-PC controls, sampled only in an accepting HOLD cycle
//   imem_req/addr          fetch request and word address (addr is the PC register)
//   imem_ack/rdata         memory response
//   instr/instr_valid      held instruction to decode
//   instr_ready            decode accepts the held instruction
//   pc, pc_plus1           address of instr and its link value
//   instr_count            accepted-instruction counter (wraps)
import cpu_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_src,
    input  logic        branch_cond,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] rs_value,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic [31:0] instr_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  next_pc_w;

    next_pc u_next_pc (
        .pc_plus1      (pc_plus1),
        .pc_src        (pc_src),
        .branch_cond   (branch_cond),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .rs_value      (rs_value),
        .next_pc       (next_pc_w)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    pc_d    = next_pc_w;
                    count_d = count_q + 32'd1;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs come straight from the state register so they drop
    // together with an asynchronous reset.
    assign imem_req    = (state_q == StReq);
    assign instr_valid = (state_q == StHold);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus1    = pc_q + 32'd1;
    assign instr       = instr_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// fetches, checked against a PC/counter/memory reference model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        branch_cond;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] rs_value;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] instr_count;

    int checks;
    int errors;

    logic [31:0] model_pc;
    logic [31:0] model_count;

    instr_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .branch_cond   (branch_cond),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .rs_value      (rs_value),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of word address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Next PC from the architectural rules, with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic cond, input logic [15:0] off,
                                             input logic [25:0] jt, input logic [31:0] rs);
        logic [31:0] seq;
        seq = cur + 32'd1;
        if (src == 2'b00) return cond ? seq + 32'($signed(off)) : seq;
        if (src == 2'b01) return (seq & 32'hFC00_0000) | {6'd0, jt};
        if (src == 2'b10) return rs;
        return seq;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Junk on the next-PC inputs; must be ignored outside an accepting cycle.
    task automatic scramble_side();
        pc_src        = 2'($urandom);
        branch_cond   = 1'($urandom);
        branch_offset = 16'($urandom);
        jump_target   = 26'($urandom);
        rs_value      = $urandom;
    endtask

    // Entered at a negedge with the DUT in REQ; returns at the negedge after acceptance.
    task automatic fetch(input int ack_dly, input int rdy_dly, input logic [1:0] src,
                         input logic cond, input logic [15:0] off, input logic [25:0] jt,
                         input logic [31:0] rs);
        logic [31:0] word;
        logic [31:0] exp_pc;
        word = mem_word(model_pc);
        check("req_in_req", {31'd0, imem_req}, 32'd1);
        check("addr_in_req", imem_addr, model_pc);
        check("valid_in_req", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom);
            scramble_side();
            @(negedge clk);
            check("req_stall", {31'd0, imem_req}, 32'd1);
            check("addr_stall", imem_addr, model_pc);
            check("valid_stall", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'($urandom);
        scramble_side();
        @(negedge clk);
        for (int i = 0; i <= rdy_dly; i++) begin
            check("valid_hold", {31'd0, instr_valid}, 32'd1);
            check("req_hold", {31'd0, imem_req}, 32'd0);
            check("instr_hold", instr, word);
            check("pc_hold", pc, model_pc);
            check("pc_plus1_hold", pc_plus1, model_pc + 32'd1);
            check("count_hold", instr_count, model_count);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            if (i < rdy_dly) begin
                instr_ready = 1'b0;
                scramble_side();
                @(negedge clk);
            end else begin
                instr_ready   = 1'b1;
                pc_src        = src;
                branch_cond   = cond;
                branch_offset = off;
                jump_target   = jt;
                rs_value      = rs;
            end
        end
        @(negedge clk);
        exp_pc      = ref_next(model_pc, src, cond, off, jt, rs);
        model_pc    = exp_pc;
        model_count = model_count + 32'd1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        check("req_after_accept", {31'd0, imem_req}, 32'd1);
        check("valid_after_accept", {31'd0, instr_valid}, 32'd0);
        check("addr_after_accept", imem_addr, exp_pc);
        check("count_after_accept", instr_count, model_count);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_pc_plus1"}, pc_plus1, 32'h1);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_count"}, instr_count, 32'h0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_pc    = 32'h0;
        model_count = 32'h0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        scramble_side();

        // Reset values, then one full IDLE cycle before the first request.
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        check("idle_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);

        // Sequential at full throughput.
        for (int i = 0; i < 3; i++) fetch(0, 0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0);
        check("seq_addr3", imem_addr, 32'h3);
        check("seq_count3", instr_count, 32'd3);

        // Branches around pc 0x10.
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'h10);
        fetch(0, 0, 2'b00, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        check("branch_taken", imem_addr, 32'h0D);
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'h10);
        fetch(0, 0, 2'b00, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        check("branch_not_taken", imem_addr, 32'h11);
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'h10);
        fetch(0, 0, 2'b00, 1'b1, 16'hFFFF, 26'h0, 32'h0);
        check("branch_self_loop", imem_addr, 32'h10);

        // Jump keeps the top bits of pc+1; register jump.
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'hF000_0005);
        fetch(0, 0, 2'b01, 1'b0, 16'h0, 26'h000_0020, 32'h0);
        check("jump_addr", imem_addr, 32'hF000_0020);
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'h1234);
        check("reg_addr", imem_addr, 32'h1234);

        // Memory and consumer stalls.
        fetch(3, 5, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0);
        check("stall_addr", imem_addr, 32'h1235);

        // PC wrap.
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF);
        fetch(0, 0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // Randomized fetches.
        for (int n = 0; n < 40; n++) begin
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom),
                  1'($urandom), 16'($urandom), 26'($urandom), $urandom);
        end

        // Reset while a request is pending; a stray ack in IDLE is ignored.
        fetch(0, 0, 2'b10, 1'b0, 16'h0, 26'h0, 32'h0000_0777);
        check("pre_reset_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_pc    = 32'h0;
        model_count = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray_ack_idle_valid", {31'd0, instr_valid}, 32'd0);
        check("stray_ack_idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("first_fetch_addr", imem_addr, 32'h0);
        fetch(1, 1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0);
        fetch(0, 2, 2'b00, 1'b1, 16'h0040, 26'h0, 32'h0);
        check("post_reset_count", instr_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
